// File: rtl/frame_rx_pkg.sv
// frame_rx_pkg: shared frame constants, state enum and frame array type for frame_rx and the segment decoder
package frame_rx_pkg;
  localparam int FRAME_LEN = 20;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;
  typedef logic [FRAME_LEN-1:0][7:0] frame_t;
endpackage

// File: rtl/frame_timer.sv
// frame_timer: idle-cycle counter; clk/rst_n, clear and enable in, one-cycle expired pulse out (suppressed by clear)
module frame_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign expired = enable && !clear && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clear || expired) ? '0 : enable ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/frame_rx.sv
// frame_rx: sync/checksum frame receiver; in_byte/in_valid in, data (last good payload), frame_valid, frame_stb, err_stb out
module frame_rx #(
  parameter int FRAME_LEN      = frame_rx_pkg::FRAME_LEN,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                in_byte,
  input  logic                      in_valid,
  output logic [FRAME_LEN-1:0][7:0] data,
  output logic                      frame_valid,
  output logic                      frame_stb,
  output logic                      err_stb
);
  import frame_rx_pkg::*;
  localparam int IW = $clog2(FRAME_LEN);
  state_t                    state;
  logic [IW-1:0]             idx;
  logic [7:0]                acc;
  logic [FRAME_LEN-1:0][7:0] shadow;
  logic                      expired;
  frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (in_valid || state == HUNT),
    .enable (state != HUNT),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= HUNT;
      idx         <= '0;
      acc         <= '0;
      shadow      <= '0;
      data        <= '0;
      frame_valid <= 1'b0;
      frame_stb   <= 1'b0;
      err_stb     <= 1'b0;
    end else begin
      frame_stb <= 1'b0;
      err_stb   <= 1'b0;
      if (expired) begin
        state   <= HUNT;
        err_stb <= 1'b1;
      end else if (in_valid)
        case (state)
          HUNT:
            if (in_byte == SYNC_BYTE) begin
              state <= PAYLOAD;
              idx   <= '0;
              acc   <= '0;
            end
          PAYLOAD: begin
            shadow[idx] <= in_byte;
            acc         <= acc + in_byte;
            idx         <= idx + 1'b1;
            if (idx == IW'(FRAME_LEN - 1)) state <= CHECK;
          end
          CHECK: begin
            state <= HUNT;
            if (8'(acc + in_byte) == 8'h00) begin
              data        <= shadow;
              frame_valid <= 1'b1;
              frame_stb   <= 1'b1;
            end else err_stb <= 1'b1;
          end
          default: state <= HUNT;
        endcase
    end
endmodule

// File: tb/tb_frame_rx.sv
// tb_frame_rx: directed scoreboard bench for frame_rx
module tb_frame_rx;
  import frame_rx_pkg::*;
  localparam int T = 1000;
  localparam int W = $bits(frame_t);
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       in_valid = 1'b0;
  frame_t     data;
  logic       frame_valid, frame_stb, err_stb;
  int         passed = 0, total = 0, stb_cnt = 0, err_cnt = 0;
  frame_t     exp_q[$];
  frame_t     f1, f2, f3, fa, fb;
  int         s_stb, s_err;
  always #5 clk = ~clk;
  frame_rx #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .data       (data),
    .frame_valid(frame_valid),
    .frame_stb  (frame_stb),
    .err_stb    (err_stb)
  );
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  function automatic logic [7:0] cks(input frame_t p);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < FRAME_LEN; i++) s = s + p[i];
    return 8'h00 - s;
  endfunction
  task automatic send_byte(input logic [7:0] b);
    in_byte  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input frame_t p, input logic [7:0] c);
    send_byte(SYNC_BYTE);
    for (int i = 0; i < FRAME_LEN; i++) send_byte(p[i]);
    if (8'(cks(p) - c) == 8'h00) exp_q.push_back(p);
    send_byte(c);
  endtask
  task automatic settle();
    idle(2);
    @(negedge clk);
    #1;
  endtask
  task automatic mark();
    s_stb = stb_cnt;
    s_err = err_cnt;
  endtask
  always @(negedge clk)
    if (rst_n) begin
      if (frame_stb || err_stb) chk("stb_exclusive", W'(frame_stb && err_stb), '0);
      if (err_stb) err_cnt++;
      if (frame_stb) begin
        stb_cnt++;
        if (exp_q.size() == 0) chk("sb_pending_on_stb", W'(exp_q.size()), W'(1));
        else chk("sb_data", data, exp_q.pop_front());
      end
    end
  initial begin
    for (int i = 0; i < FRAME_LEN; i++) begin
      f1[i] = 8'(i + 1);
      f2[i] = 8'(3 * i + 7);
      f3[i] = 8'(i * 11 + 2);
      fa[i] = 8'hA5;
      fb[i] = 8'(255 - i);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", data, '0);
    chk("rst_frame_valid", W'(frame_valid), '0);
    chk("rst_stbs", W'({frame_stb, err_stb}), '0);
    rst_n = 1'b1;
    idle(2);
    mark();
    send_frame(f1, 8'h2E);
    settle();
    chk("good_stb_count", W'(stb_cnt - s_stb), W'(1));
    chk("good_err_count", W'(err_cnt - s_err), '0);
    chk("good_frame_valid", W'(frame_valid), W'(1));
    chk("good_data0", W'(data[0]), W'(8'h01));
    chk("good_data19", W'(data[19]), W'(8'h14));
    mark();
    send_frame(f1, 8'h2F);
    settle();
    chk("bad_err_count", W'(err_cnt - s_err), W'(1));
    chk("bad_stb_count", W'(stb_cnt - s_stb), '0);
    chk("bad_data_kept", data, f1);
    mark();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    settle();
    chk("garbage_err_count", W'(err_cnt - s_err), '0);
    send_frame(f2, cks(f2));
    settle();
    chk("garbage_then_frame_stb", W'(stb_cnt - s_stb), W'(1));
    chk("garbage_then_frame_data", data, f2);
    mark();
    send_byte(SYNC_BYTE);
    for (int i = 0; i < 5; i++) send_byte(8'h33);
    idle(T - 1);
    @(negedge clk);
    #1;
    chk("timeout_early_err", W'(err_cnt - s_err), '0);
    idle(1);
    @(negedge clk);
    #1;
    chk("timeout_err", W'(err_cnt - s_err), W'(1));
    idle(3);
    chk("timeout_err_once", W'(err_cnt - s_err), W'(1));
    chk("timeout_data_kept", data, f2);
    send_frame(f3, cks(f3));
    settle();
    chk("after_timeout_stb", W'(stb_cnt - s_stb), W'(1));
    chk("after_timeout_data", data, f3);
    mark();
    send_byte(SYNC_BYTE);
    for (int i = 0; i < 5; i++) send_byte(f1[i]);
    idle(T - 1);
    for (int i = 5; i < FRAME_LEN; i++) send_byte(f1[i]);
    exp_q.push_back(f1);
    send_byte(8'h2E);
    settle();
    chk("byte_at_expiry_err", W'(err_cnt - s_err), '0);
    chk("byte_at_expiry_stb", W'(stb_cnt - s_stb), W'(1));
    mark();
    send_byte(SYNC_BYTE);
    for (int i = 0; i < 10; i++) send_byte(8'h01);
    rst_n = 1'b0;
    #1;
    chk("midrst_data", data, '0);
    chk("midrst_frame_valid", W'(frame_valid), '0);
    chk("midrst_stbs", W'({frame_stb, err_stb}), '0);
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) send_byte(8'h01);
    send_byte(8'hEC);
    settle();
    chk("midrst_partial_discarded", W'({stb_cnt - s_stb, err_cnt - s_err}), '0);
    chk("midrst_valid_still_low", W'(frame_valid), '0);
    send_frame(fa, 8'h1C);
    settle();
    chk("a5_frame_stb", W'(stb_cnt - s_stb), W'(1));
    chk("a5_frame_data", data, fa);
    mark();
    send_frame(f2, cks(f2));
    send_frame(fb, cks(fb));
    settle();
    chk("b2b_stb_count", W'(stb_cnt - s_stb), W'(2));
    chk("b2b_err_count", W'(err_cnt - s_err), '0);
    chk("b2b_data", data, fb);
    chk("sb_drained", W'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/frame_rx.md
FRAME_RX -- requirements
Module: frame_rx

Interface
REQ-001 Parameter: FRAME_LEN, 20, payload bytes per frame; equals the depth of the segment decoder's data array.
REQ-002 Parameter: TIMEOUT_CYCLES, 1000, idle clock cycles allowed between bytes inside a frame before it is abandoned.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 Port: in_byte  input  8  received byte, qualified by in_valid.
REQ-006 Port: in_valid  input  1  one-cycle strobe per byte; back-to-back cycles allowed.
REQ-007 Port: data  output  [7:0] x FRAME_LEN  last good payload; element 0 is the first payload byte; feeds the segment decoder directly.
REQ-008 Port: frame_valid  output  1  high once any good frame has been stored.
REQ-009 Port: frame_stb  output  1  one-cycle pulse when data updates.
REQ-010 Port: err_stb  output  1  one-cycle pulse on checksum failure or timeout.

Function
REQ-011 Frame on the wire SHALL be: SYNC_BYTE (0xA5), FRAME_LEN payload bytes, 1 checksum byte.
REQ-012 A frame is good when (sum of payload bytes + checksum byte) mod 256 == 0, using an 8-bit wrap-around accumulator.
REQ-013 States: HUNT, PAYLOAD, CHECK; reset state is HUNT.
REQ-014 HUNT: a byte equal to 0xA5 moves to PAYLOAD and clears the index and accumulator; all other bytes are ignored with no error.
REQ-015 PAYLOAD: each byte is written to shadow[index] and added to the accumulator, and the index increments. After byte FRAME_LEN-1 the state moves to CHECK.
REQ-016 A 0xA5 byte inside PAYLOAD is payload data; it does not resynchronise.
REQ-017 CHECK, good checksum: on the edge that samples the checksum byte, data is loaded from shadow (all bytes at once), frame_valid is set, frame_stb is high for the following cycle only, and the state returns to HUNT.
REQ-018 CHECK, bad checksum: data is unchanged, err_stb pulses for one cycle, and the state returns to HUNT.
REQ-019 Timeout: in PAYLOAD or CHECK, TIMEOUT_CYCLES consecutive cycles without in_valid force HUNT, pulse err_stb once, and leave data unchanged. The counter clears on every accepted byte and is held at 0 in HUNT.
REQ-020 data SHALL never show a partially updated frame; the shadow buffer is separate from the data register.
REQ-021 in_valid on the same cycle as a timeout expiry: the byte wins, the counter clears, and there is no error.
REQ-022 frame_stb and err_stb SHALL never be high in the same cycle.
REQ-023 Latency from the checksum byte's in_valid edge to data/frame_stb visible is exactly 1 cycle.

Reset
REQ-024 While rst_n is low, the block SHALL hold: state HUNT, data all 0x00, shadow, index, accumulator and timer at 0, and frame_valid, frame_stb, err_stb at 0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; after release, the block requires a fresh SYNC_BYTE.

Structure
REQ-026 A shared package SHALL hold FRAME_LEN, SYNC_BYTE, the state enum type, and the frame array typedef, shared with the segment decoder and its tests.
REQ-027 The timeout counter SHALL be a sub-module, frame_timer (inputs clear/enable; output expired pulse).
REQ-028 Byte-source timing (UART or other) is out of scope; the block consumes only in_byte/in_valid.

Verification
REQ-029 Good frame: sequence 0xA5, payload 0x01..0x14, checksum 0x2E -> data[0]=0x01, data[19]=0x14, one frame_stb pulse, frame_valid=1.
REQ-030 Bad checksum: same frame with checksum 0x2F -> err_stb one cycle, data keeps its previous contents, frame_stb stays 0.
REQ-031 Garbage then sync: bytes 0x00, 0xFF, 0x5A, then a good frame -> no err_stb before the frame; frame accepted normally.
REQ-032 Timeout: send 0xA5 and 5 payload bytes, then idle TIMEOUT_CYCLES cycles -> err_stb exactly once; a subsequent good frame is accepted.
REQ-033 Reset mid-frame: rst_n low after 10 payload bytes -> all outputs 0; after release, a good frame with payload all 0xA5 (checksum 0x1C) gives data all 0xA5.
REQ-034 Back-to-back: two good frames with in_valid high every cycle -> two frame_stb pulses; data equals the second frame.
